// File: rtl/apb_pkg.sv
// Shared APB definitions: slave FSM state encoding, response codes and a
// helper that gives the number of byte-offset address bits for a data width.
package apb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_slv_state_t;

    localparam logic OKAY   = 1'b0;
    localparam logic SLVERR = 1'b1;

    function automatic int clog2_bytes(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/apb_bytemem.sv
// DEPTH x DATA_WIDTH storage with a synchronous byte-enable write port and an
// asynchronous read port. Contents are deliberately not reset.
module apb_bytemem #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64
) (
    input  logic                        clk_i,
    input  logic                        we_i,
    input  logic [$clog2(DEPTH)-1:0]    waddr_i,
    input  logic [DATA_WIDTH-1:0]       wdata_i,
    input  logic [DATA_WIDTH/8-1:0]     strb_i,
    input  logic [$clog2(DEPTH)-1:0]    raddr_i,
    output logic [DATA_WIDTH-1:0]       rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < DATA_WIDTH / 8; i++) begin
                if (strb_i[i]) begin
                    mem_q[waddr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/apb_mem_slave.sv
// APB4 memory slave with byte strobes, WAIT_STATES programmable wait cycles and
// PSLVERR on misaligned/out-of-range accesses. Define APB_MEM_SLAVE_PROT_EN to
// reject unprivileged writes to the upper half of the array.
module apb_mem_slave
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [2:0]              PPROT,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);

    localparam int OFS = clog2_bytes(DATA_WIDTH);
    localparam int IW  = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] OFS_MASK  = ADDR_WIDTH'((1 << OFS) - 1);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A   = ADDR_WIDTH'(DEPTH);
    localparam logic [3:0]            WAIT_INIT = 4'(WAIT_STATES);

    apb_slv_state_t        state_q;
    logic [3:0]            cnt_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] prdata_q;

    logic [IW-1:0]         idx;
    logic                  misaligned;
    logic                  out_of_range;
    logic                  prot_err;
    logic                  setup_err;
    logic                  setup;
    logic                  pready;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;

    assign idx          = PADDR[OFS +: IW];
    assign misaligned   = |(PADDR & OFS_MASK);
    assign out_of_range = (PADDR >> OFS) >= DEPTH_A;

`ifdef APB_MEM_SLAVE_PROT_EN
    // Upper half of a power-of-two array is exactly the index MSB.
    assign prot_err = PWRITE && !PPROT[0] && idx[IW-1];
`else
    logic unused_pprot;
    assign unused_pprot = ^PPROT;
    assign prot_err     = 1'b0;
`endif

    assign setup_err = misaligned || out_of_range || prot_err;
    assign setup     = PSEL && !PENABLE;
    assign pready    = (state_q == ACCESS) && PSEL && PENABLE && (cnt_q == 4'd0);
    assign mem_we    = pready && PWRITE && !err_q;

    apb_bytemem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk_i   (PCLK),
        .we_i    (mem_we),
        .waddr_i (idx),
        .wdata_i (PWDATA),
        .strb_i  (PSTRB),
        .raddr_i (idx),
        .rdata_o (mem_rdata)
    );

    // PRDATA is captured at setup so it is stable through every wait cycle.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            err_q    <= 1'b0;
            prdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (setup) begin
                        state_q <= ACCESS;
                        cnt_q   <= WAIT_INIT;
                        err_q   <= setup_err;
                        if (!PWRITE) begin
                            prdata_q <= setup_err ? '0 : mem_rdata;
                        end
                    end
                end
                ACCESS: begin
                    if (!PSEL) begin
                        state_q <= IDLE;
                    end else if (PENABLE) begin
                        if (cnt_q != 4'd0) begin
                            cnt_q <= cnt_q - 4'd1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign PRDATA  = prdata_q;
    assign PREADY  = pready;
    assign PSLVERR = (pready && err_q) ? SLVERR : OKAY;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed bench for apb_mem_slave: one zero-wait and one three-wait instance,
// DATA_WIDTH=32, DEPTH=64, sharing a single APB master selected by sel.
module tb_apb_mem_slave;

    logic        clk;
    logic        rst_n;
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        sel;

    logic [31:0] prdata0, prdata3, prdata_m;
    logic        pready0, pready3, pready_m;
    logic        pslverr0, pslverr3, pslverr_m;
    logic        psel0, psel3;

    int errors = 0;
    int checks = 0;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign psel0     = psel && !sel;
    assign psel3     = psel && sel;
    assign prdata_m  = sel ? prdata3  : prdata0;
    assign pready_m  = sel ? pready3  : pready0;
    assign pslverr_m = sel ? pslverr3 : pslverr0;

    apb_mem_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(64), .WAIT_STATES(0)
    ) dut_ws0 (
        .PCLK(clk), .PRESETn(rst_n), .PADDR(paddr), .PPROT(pprot),
        .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite), .PWDATA(pwdata),
        .PSTRB(pstrb), .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0)
    );

    apb_mem_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(64), .WAIT_STATES(3)
    ) dut_ws3 (
        .PCLK(clk), .PRESETn(rst_n), .PADDR(paddr), .PPROT(pprot),
        .PSEL(psel3), .PENABLE(penable), .PWRITE(pwrite), .PWDATA(pwdata),
        .PSTRB(pstrb), .PRDATA(prdata3), .PREADY(pready3), .PSLVERR(pslverr3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // driver: one full transfer, entered and left at posedge+1
    task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                            input logic [3:0] strb, input logic [2:0] prot,
                            output logic [31:0] rdata, output logic err,
                            output int cycles, output int low_cnt, output logic stable);
        logic [31:0] first;
        logic        done;
        paddr = addr; pwrite = wr; pwdata = wdata; pstrb = strb; pprot = prot;
        psel = 1'b1; penable = 1'b0;
        cycles = 1; low_cnt = 0; stable = 1'b1; done = 1'b0; first = '0;
        @(posedge clk); #1;
        penable = 1'b1;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            cycles++;
            if (k == 0) first = prdata_m;
            else if (prdata_m !== first) stable = 1'b0;
            if (pready_m) begin
                done = 1'b1;
            end else begin
                low_cnt++;
                @(posedge clk); #1;
            end
        end
        if (!done) check("ready_timeout", {31'd0, pready_m}, 32'd1);
        rdata = prdata_m;
        err   = pslverr_m;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          cyc;
    int          low;
    logic        stb;

    initial begin
        rst_n = 1'b0; sel = 1'b0;
        paddr = '0; pprot = '0; psel = 1'b0; penable = 1'b0;
        pwrite = 1'b0; pwdata = '0; pstrb = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pready0",  {31'd0, pready0},  32'd0);
        check("rst_pslverr0", {31'd0, pslverr0}, 32'd0);
        check("rst_prdata0",  prdata0,           32'd0);
        check("rst_pready3",  {31'd0, pready3},  32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // stray PENABLE without setup is ignored
        penable = 1'b1;
        @(negedge clk);
        check("stray_enable_pready", {31'd0, pready0}, 32'd0);
        @(posedge clk); #1;
        penable = 1'b0;

        // zero-wait write then back-to-back read
        apb_xfer(32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 3'b001, rd, er, cyc, low, stb);
        check("ws0_wr_cycles", cyc, 2);
        check("ws0_wr_err",    {31'd0, er}, 32'd0);
        apb_xfer(32'h10, 1'b0, 32'h0, 4'h0, 3'b001, rd, er, cyc, low, stb);
        check("ws0_rd_cycles", cyc, 2);
        check("ws0_rd_data",   rd, 32'hDEADBEEF);
        check("ws0_rd_err",    {31'd0, er}, 32'd0);

        // byte strobes
        apb_xfer(32'h20, 1'b1, 32'hAABBCCDD, 4'hF, 3'b001, rd, er, cyc, low, stb);
        apb_xfer(32'h20, 1'b1, 32'h11223344, 4'h5, 3'b001, rd, er, cyc, low, stb);
        apb_xfer(32'h20, 1'b0, 32'h0, 4'h0, 3'b001, rd, er, cyc, low, stb);
        check("strb_data", rd, 32'hAA22CC44);

        // out of range read
        apb_xfer(32'h100, 1'b0, 32'h0, 4'h0, 3'b001, rd, er, cyc, low, stb);
        check("oor_rd_err",  {31'd0, er}, 32'd1);
        check("oor_rd_data", rd, 32'd0);

        // misaligned writes must leave the array unchanged (0x102 aliases word 0)
        apb_xfer(32'h00, 1'b1, 32'hCAFEF00D, 4'hF, 3'b001, rd, er, cyc, low, stb);
        apb_xfer(32'h102, 1'b1, 32'hFFFFFFFF, 4'hF, 3'b001, rd, er, cyc, low, stb);
        check("mis_wr_err", {31'd0, er}, 32'd1);
        apb_xfer(32'h22, 1'b1, 32'hFFFFFFFF, 4'hF, 3'b001, rd, er, cyc, low, stb);
        check("mis22_wr_err", {31'd0, er}, 32'd1);
        apb_xfer(32'h100, 1'b0, 32'h0, 4'h0, 3'b001, rd, er, cyc, low, stb);
        check("oor_rd2_err", {31'd0, er}, 32'd1);
        apb_xfer(32'h00, 1'b0, 32'h0, 4'h0, 3'b001, rd, er, cyc, low, stb);
        check("word0_kept", rd, 32'hCAFEF00D);
        check("word0_err",  {31'd0, er}, 32'd0);
        apb_xfer(32'h20, 1'b0, 32'h0, 4'h0, 3'b001, rd, er, cyc, low, stb);
        check("word8_kept", rd, 32'hAA22CC44);

        // three wait states
        sel = 1'b1;
        apb_xfer(32'h04, 1'b1, 32'h12345678, 4'hF, 3'b001, rd, er, cyc, low, stb);
        check("ws3_wr_cycles", cyc, 5);
        apb_xfer(32'h04, 1'b0, 32'h0, 4'h0, 3'b001, rd, er, cyc, low, stb);
        check("ws3_rd_cycles", cyc, 5);
        check("ws3_rd_low",    low, 3);
        check("ws3_rd_stable", {31'd0, stb}, 32'd1);
        check("ws3_rd_data",   rd, 32'h12345678);

        // PSEL dropped during wait states
        paddr = 32'h04; pwrite = 1'b1; pwdata = 32'hFFFFFFFF; pstrb = 4'hF; pprot = 3'b001;
        psel = 1'b1; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        check("abort_wait_ready", {31'd0, pready3}, 32'd0);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        check("abort_drop_ready", {31'd0, pready3}, 32'd0);
        @(posedge clk); #1;
        apb_xfer(32'h04, 1'b0, 32'h0, 4'h0, 3'b001, rd, er, cyc, low, stb);
        check("abort_no_write", rd, 32'h12345678);
        check("abort_cycles",   cyc, 5);

        // reset pulse in the zero-wait access phase
        sel = 1'b0;
        apb_xfer(32'h00, 1'b0, 32'h0, 4'h0, 3'b001, rd, er, cyc, low, stb);
        paddr = 32'h10; pwrite = 1'b1; pwdata = 32'h00000000; pstrb = 4'hF;
        psel = 1'b1; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_pready", {31'd0, pready0}, 32'd0);
        check("rst_mid_prdata", prdata0, 32'd0);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        apb_xfer(32'h10, 1'b0, 32'h0, 4'h0, 3'b001, rd, er, cyc, low, stb);
        check("rst_mid_kept", rd, 32'hDEADBEEF);

        // protection of the upper half (word 32 at 0x80)
        apb_xfer(32'h80, 1'b1, 32'h01010101, 4'hF, 3'b001, rd, er, cyc, low, stb);
        check("prot_priv_err", {31'd0, er}, 32'd0);
        apb_xfer(32'h80, 1'b1, 32'h00000BAD, 4'hF, 3'b000, rd, er, cyc, low, stb);
`ifdef APB_MEM_SLAVE_PROT_EN
        check("prot_user_err", {31'd0, er}, 32'd1);
        apb_xfer(32'h80, 1'b0, 32'h0, 4'h0, 3'b000, rd, er, cyc, low, stb);
        check("prot_user_dropped", rd, 32'h01010101);
        check("prot_user_rd_err",  {31'd0, er}, 32'd0);
`else
        check("prot_user_err", {31'd0, er}, 32'd0);
        apb_xfer(32'h80, 1'b0, 32'h0, 4'h0, 3'b000, rd, er, cyc, low, stb);
        check("prot_user_written", rd, 32'h00000BAD);
`endif
        apb_xfer(32'h80, 1'b1, 32'h0000600D, 4'hF, 3'b001, rd, er, cyc, low, stb);
        check("prot_priv2_err", {31'd0, er}, 32'd0);
        apb_xfer(32'h80, 1'b0, 32'h0, 4'h0, 3'b001, rd, er, cyc, low, stb);
        check("prot_priv_data", rd, 32'h0000600D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_mem_slave.md
# apb_mem_slave

Parametrised APB4 memory-mapped slave: a DEPTH-word register/memory array with byte-strobe writes, programmable wait states and PSLVERR on illegal accesses. It is the next-generation on-chip APB target for the UVC bench and for peripheral shells. It replaces the fixed 8-bit, zero-wait, no-strobe slave.

## Interface
- ADDR_WIDTH, 32: PADDR width.
- DATA_WIDTH, 32: data width; legal values 8, 16, 32.
- DEPTH, 64: number of words; power of two, at least 2.
- WAIT_STATES, 0: PREADY-low cycles inserted in each access phase; range 0..15.
- PCLK  in  1  clock; all logic on the rising edge.
- PRESETn  in  1  asynchronous, active-low reset.
- PADDR  in  ADDR_WIDTH  byte address.
- PPROT  in  3  protection attributes.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  DATA_WIDTH/8  write byte lanes; ignored on reads.
- PRDATA  out  DATA_WIDTH  read data; registered.
- PREADY  out  1  transfer complete; combinational from registered state.
- PSLVERR  out  1  error; valid only while PREADY=1, otherwise 0.

## Operation
- Derived constants:
  - OFS = log2(DATA_WIDTH/8), the byte-offset bits.
  - IDX = PADDR[OFS +: log2(DEPTH)], the word index.
- Error condition, evaluated in the setup phase and registered as err_q:
  - PADDR[OFS-1:0] != 0 (misaligned), or
  - PADDR >> OFS >= DEPTH (out of range).
- State machine, states IDLE and ACCESS:
  - IDLE: if PSEL=1 and PENABLE=0 (setup phase), load cnt=WAIT_STATES, latch err_q, and go to ACCESS.
  - IDLE: PENABLE=1 without a preceding setup phase is ignored. State stays IDLE and PREADY=0.
  - ACCESS: if PSEL=0, abort to IDLE with no memory write.
  - ACCESS with PSEL=1 and PENABLE=1 and cnt != 0: decrement cnt; PREADY=0.
  - ACCESS with cnt == 0: PREADY=1; go to IDLE at this edge.
- PREADY = (state == ACCESS) && PSEL && PENABLE && (cnt == 0).
- PSLVERR = PREADY && err_q.
- Write: committed at the edge where PREADY=1, only if err_q=0. Each byte lane i is written only where PSTRB[i]=1.
- Read: PRDATA is loaded at the setup-phase edge with mem[IDX], or with 0 if the access errors. It holds its value until the next read setup.
- Back-to-back transfers: a new setup phase in the cycle after completion is accepted from IDLE with no idle cycle required.
- Reset:
  - State=IDLE, cnt=0, err_q=0, PRDATA=0, so PREADY=0 and PSLVERR=0.
  - Memory is not reset.
  - Reset asserted mid-access discards that transfer with no partial write.

## Timing
- Transfer length is 2+WAIT_STATES cycles: one setup cycle, then WAIT_STATES cycles with PREADY low, then one cycle with PREADY high.
- Read data is stable on PRDATA from the first access cycle onward.
- A written value is visible to a read whose setup phase begins the cycle after the write completes.

## Configuration
- APB_MEM_SLAVE_PROT_EN defined:
  - A write with PPROT[0]=0 (unprivileged) to the upper half of the array (IDX >= DEPTH/2) sets err_q.
  - That write is dropped and completes with PSLVERR=1.
  - Reads are unaffected.
- Undefined: PPROT is ignored; no protection errors are raised.

## Structure
- Shared package apb_pkg holds:
  - the state typedef apb_slv_state_t {IDLE, ACCESS};
  - the function clog2_bytes(DATA_WIDTH);
  - the response constants OKAY and SLVERR.
- Sub-module apb_bytemem holds the DEPTH x DATA_WIDTH array.
  - Ports: synchronous byte-enable write, and read by index.
  - The top level owns the FSM, wait counter and error decode.

## Test plan
All scenarios use DATA_WIDTH=32 and DEPTH=64.
- WAIT_STATES=0: write 0xDEADBEEF to 0x10 with PSTRB=0xF, then read 0x10 → each transfer takes 2 cycles, PRDATA=0xDEADBEEF, PSLVERR=0.
- Byte strobes: write 0xAABBCCDD to 0x20, then write 0x11223344 to 0x20 with PSTRB=0x5 → read returns 0xAA22CC44.
- WAIT_STATES=3: read 0x04 → PREADY is low for 3 access cycles, the transfer takes 5 cycles, and PRDATA is stable throughout.
- Illegal addresses:
  - Read 0x100 (out of range) → PSLVERR=1, PRDATA=0.
  - Write 0x102 (misaligned) → PSLVERR=1, and a later read of 0x100 still errors while array contents are unchanged.
- Mid-transfer events:
  - PSEL dropped during wait states → no write, FSM returns to IDLE.
  - PRESETn pulsed mid-access → PREADY=0, PRDATA=0, and the target word is unchanged.
- With APB_MEM_SLAVE_PROT_EN: write to 0x80 with PPROT=3'b000 → PSLVERR=1 and no write; the same write with PPROT=3'b001 → OKAY and the data is written.
